fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction prefetch buffer between the instruction fetch phase and the IF/ID register. It decouples fetch from decode stalls: fetch pushes {PC+4, instruction} pairs while the buffer has space, and decode pops them under a valid/ready handshake. A redirect flush (taken branch, jump, jump-register) discards all buffered entries in one cycle. This allows the fetch phase to keep running while the `PCWrite` hazard stall holds decode.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.
- `ADDR_W`, default 32: width of the stored PC field.
- `INSTR_W`, default 32: width of the stored instruction field.
- `AFULL_THRESH`, default `DEPTH-1`: occupancy at or above which `almost_full` asserts; legal range 1..`DEPTH`.

- `Clk`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `enq_valid`  in  1  fetch presents an entry.
- `enq_pc`  in  `ADDR_W`  PC+4 of the fetched instruction.
- `enq_instr`  in  `INSTR_W`  fetched instruction word.
- `enq_ready`  out  1  the buffer accepts an entry this cycle.
- `deq_valid`  out  1  the head entry is available.
- `deq_pc`  out  `ADDR_W`  PC field of the head entry.
- `deq_instr`  out  `INSTR_W`  instruction field of the head entry.
- `deq_ready`  in  1  decode consumes the head entry this cycle.
- `Flush`  in  1  redirect; discard all entries.
- `count`  out  `$clog2(DEPTH)+1`  current occupancy, 0..`DEPTH`.
- `almost_full`  out  1  `count >= AFULL_THRESH`.

## Operation
- **Storage.** Circular buffer of `DEPTH` entries. Write pointer and read pointer are each `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. A separate `count` register disambiguates the full and empty states.
- **Handshakes.**
  - An enqueue occurs when `enq_valid && enq_ready`.
  - A dequeue occurs when `deq_valid && deq_ready`.
- **`enq_ready`** = `(count != DEPTH) && !Flush`. It depends only on state and `Flush`; there is no combinational path from `deq_ready`, so a full buffer refuses an enqueue even when a dequeue happens in the same cycle.
- **`deq_valid`** = `(count != 0) && !Flush`.
- **`deq_pc` / `deq_instr`** are read combinationally from the entry at the read pointer. They are stable while `deq_valid` is high and `deq_ready` is low.
- **Simultaneous enqueue and dequeue** (buffer neither empty nor full): both pointers advance and `count` is unchanged.
- **`Flush`** has priority over enqueue and dequeue in the same cycle. At the next edge both pointers and `count` go to 0, and any entry presented that cycle is discarded. Stored data is not cleared.
- **Illegal handshakes.** `deq_ready` while empty and `enq_valid` while full are both ignored, with no state change.
- **Reset.** While `Reset` is high:
  - pointers and `count` are 0;
  - all storage entries are 0;
  - `deq_valid`=0, `deq_pc`=0, `deq_instr`=0, `almost_full`=0 (given `AFULL_THRESH` ≥ 1), `enq_ready`=1.
- **Reset mid-operation** drops all entries immediately, asynchronously.

## Timing
- Without bypass, latency is 1 cycle: an entry enqueued at edge N is visible on `deq_*` in the cycle after edge N.
- Sustained throughput is 1 entry per cycle when `DEPTH` ≥ 2 and both sides are ready.
- `count` and `almost_full` are registered. They reflect the state after the last edge and do not reflect the current cycle's handshakes.
- `Flush` gates `deq_valid` and `enq_ready` combinationally within the same cycle. Its state effect takes place at the next edge.

## Configuration
- **`FETCHQ_BYPASS_EN` defined:**
  - When `count == 0`, `enq_valid`=1, `deq_ready`=1 and `Flush`=0, the entry passes straight to `deq_*` in the same cycle.
  - In that case `deq_valid`=1, nothing is written, and pointers and `count` are unchanged.
  - This adds a combinational path from `enq_*` to `deq_*`.
- **`FETCHQ_BYPASS_EN` undefined:** no bypass; minimum latency is 1 cycle as described under Timing.

## Test plan
- **Reset then fill.** Hold `deq_ready`=0 and push entries (pc=0x4,0x8,0xC,0x10), instr=0xA0000001..4 with `DEPTH`=4. Required: `enq_ready` drops after the 4th push, `count`=4, and `almost_full` rises when `count` reaches 3.
- **Drain in order.** From full, set `deq_ready`=1. Required: `deq_pc` reads 0x4, 0x8, 0xC, 0x10 on consecutive cycles, then `deq_valid`=0 and `count`=0. Pointers wrap cleanly on a second fill/drain of 6 entries.
- **Concurrent enqueue and dequeue.** Hold `count`=2 with continuous enqueue and dequeue for 10 cycles. Required: `count` stays 2 and the output order matches the input order.
- **Flush with handshakes active.** With `count`=3, assert `Flush` for one cycle while `enq_valid`=1 and `deq_ready`=1. Required: `deq_valid`=0 and `enq_ready`=0 during that cycle, `count`=0 after the edge, and the next pushed pc=0x40 is the next entry dequeued.
- **Asynchronous reset mid-stream.** Assert `Reset` between edges with `count`=2. Required: `count`=0, `deq_valid`=0 and `deq_pc`=0 immediately, without waiting for a clock edge.
- **Bypass (`FETCHQ_BYPASS_EN`).** Empty buffer, push pc=0x20 with `deq_ready`=1. Required: `deq_pc`=0x20 in the same cycle and `count` remains 0. With the macro undefined, the same stimulus gives `deq_valid`=1 only in the following cycle.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction prefetch buffer between the fetch stage and the IF/ID
//            register. Fetch pushes {PC+4, instruction} pairs while there is
//            room. Decode pops them with a valid/ready handshake. A redirect
//            flush empties the buffer in a single cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        number of entries (power of two, >= 2)
//   ADDR_W       width of the stored PC field
//   INSTR_W      width of the stored instruction field
//   AFULL_THRESH occupancy at or above which almost_full asserts (1..DEPTH)
// Ports
//   Clk          sole clock, rising edge
//   Reset        asynchronous, active-high reset
//   enq_valid    fetch presents an entry
//   enq_pc       PC+4 of the fetched instruction
//   enq_instr    fetched instruction word
//   enq_ready    buffer accepts an entry this cycle
//   deq_valid    head entry is available
//   deq_pc       PC field of the head entry
//   deq_instr    instruction field of the head entry
//   deq_ready    decode consumes the head entry this cycle
//   Flush        redirect: discard all entries at the next edge
//   count        registered occupancy, 0..DEPTH
//   almost_full  registered (count >= AFULL_THRESH)
// Build option
//   FETCHQ_BYPASS_EN  when defined, an entry offered to an empty buffer while
//                     decode is ready goes straight to deq_* in the same
//                     cycle and is not stored.
// ============================================================================
module fetch_queue #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 32,
    parameter int INSTR_W      = 32,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     enq_valid,
    input  logic [ADDR_W-1:0]        enq_pc,
    input  logic [INSTR_W-1:0]       enq_instr,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [ADDR_W-1:0]        deq_pc,
    output logic [INSTR_W-1:0]       deq_instr,
    input  logic                     deq_ready,
    input  logic                     Flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL = c_CNT_W'(AFULL_THRESH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_almost_full;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic               w_stored_valid;
    logic               w_bypass;
    logic               w_enq;
    logic               w_deq;
    logic [c_CNT_W-1:0] w_count_nxt;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    // enq_ready looks only at state and Flush. A full buffer therefore
    // refuses an entry even when decode pops in the same cycle.
    assign enq_ready      = !w_full && !Flush;
    assign w_stored_valid = !w_empty && !Flush;

`ifdef FETCHQ_BYPASS_EN
    // Reset is included so that a fetch entry offered while reset is held
    // cannot appear on deq_*.
    assign w_bypass  = w_empty && enq_valid && deq_ready && !Flush && !Reset;
    assign deq_pc    = w_bypass ? enq_pc    : r_mem_pc[r_rd_ptr];
    assign deq_instr = w_bypass ? enq_instr : r_mem_instr[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign deq_pc    = r_mem_pc[r_rd_ptr];
    assign deq_instr = r_mem_instr[r_rd_ptr];
`endif

    assign deq_valid = w_stored_valid || w_bypass;

    // A bypassed entry is consumed in flight, so it neither writes nor pops.
    assign w_enq = enq_valid && enq_ready && !w_bypass;
    assign w_deq = w_stored_valid && deq_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (Flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_enq, w_deq})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and almost_full
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_count_nxt;
            r_almost_full <= (w_count_nxt >= c_AFULL);
            if (Flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // Pointer widths are log2(DEPTH), so they wrap on their own.
                if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: cleared on reset only. A flush just rewinds the pointers.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_enq) begin
            r_mem_pc[r_wr_ptr]    <= enq_pc;
            r_mem_instr[r_wr_ptr] <= enq_instr;
        end
    end

    assign count       = r_count;
    assign almost_full = r_almost_full;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue (DEPTH=4). A queue model
//            predicts enq_ready, deq_valid, the head data, count and
//            almost_full on every cycle. A vector table covers fill/drain.
//            Hand-written sequences cover wrap, concurrent traffic, flush,
//            asynchronous reset and the bypass path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;

    logic        Clk;
    logic        Reset;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready;
    logic        Flush;
    logic [2:0]  count;
    logic        almost_full;

    fetch_queue #(
        .DEPTH        (DEPTH),
        .ADDR_W       (32),
        .INSTR_W      (32),
        .AFULL_THRESH (AFULL)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .enq_valid   (enq_valid),
        .enq_pc      (enq_pc),
        .enq_instr   (enq_instr),
        .enq_ready   (enq_ready),
        .deq_valid   (deq_valid),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .deq_ready   (deq_ready),
        .Flush       (Flush),
        .count       (count),
        .almost_full (almost_full)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t m_q[$];

    logic       obs_er;
    logic       obs_dv;
    logic [2:0] obs_cnt;
    logic       obs_af;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive after the falling edge, check combinational
    // outputs against the model, then check registered outputs after the edge.
    task automatic run_cycle(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                             input logic dr, input logic fl);
        logic e_er;
        logic e_dv;
        logic byp;
        int   sz;
        @(negedge Clk);
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = ins;
        deq_ready = dr;
        Flush     = fl;
        #1;
        sz  = m_q.size();
        byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        byp = (sz == 0) && ev && dr && !fl;
`endif
        e_er = (sz != DEPTH) && !fl;
        e_dv = ((sz != 0) && !fl) || byp;
        chk("enq_ready", {63'd0, enq_ready}, {63'd0, e_er});
        chk("deq_valid", {63'd0, deq_valid}, {63'd0, e_dv});
        if (e_dv) begin
            chk("deq_pc",    {32'd0, deq_pc},    {32'd0, byp ? pc  : m_q[0].pc});
            chk("deq_instr", {32'd0, deq_instr}, {32'd0, byp ? ins : m_q[0].instr});
        end
        obs_er = enq_ready;
        obs_dv = deq_valid;
        @(posedge Clk);
        if (fl) begin
            m_q.delete();
        end else if (!byp) begin
            if (dr && sz != 0) void'(m_q.pop_front());
            if (ev && sz != DEPTH) m_q.push_back('{pc: pc, instr: ins});
        end
        #1;
        chk("count",       {61'd0, count},       64'(m_q.size()));
        chk("almost_full", {63'd0, almost_full}, {63'd0, (m_q.size() >= AFULL)});
        obs_cnt = count;
        obs_af  = almost_full;
    endtask

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dr;
        logic        fl;
        logic        exp_er;
        logic        exp_dv;
        logic [2:0]  exp_cnt;
        logic        exp_af;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Fill to full with decode stalled, refuse while full, then drain.
        tbl[0] = '{1'b1, 32'h4,  32'hA000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        tbl[1] = '{1'b1, 32'h8,  32'hA000_0002, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[2] = '{1'b1, 32'hC,  32'hA000_0003, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1};
        tbl[3] = '{1'b1, 32'h10, 32'hA000_0004, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1};
        tbl[4] = '{1'b1, 32'h14, 32'hA000_0005, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
        tbl[5] = '{1'b1, 32'h14, 32'hA000_0005, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1};
        tbl[6] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[7] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[8] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[9] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0};

        Reset     = 1'b1;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_instr = '0;
        deq_ready = 1'b0;
        Flush     = 1'b0;
        #12;
        chk("rst_count",     {61'd0, count},       64'd0);
        chk("rst_deq_valid", {63'd0, deq_valid},   64'd0);
        chk("rst_enq_ready", {63'd0, enq_ready},   64'd1);
        chk("rst_afull",     {63'd0, almost_full}, 64'd0);
        chk("rst_deq_pc",    {32'd0, deq_pc},      64'd0);
        chk("rst_deq_instr", {32'd0, deq_instr},   64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Vector table: reset then fill, then drain in order.
        for (int i = 0; i < 10; i++) begin
            run_cycle(tbl[i].ev, tbl[i].pc, tbl[i].instr, tbl[i].dr, tbl[i].fl);
            chk("tbl_enq_ready", {63'd0, obs_er},  {63'd0, tbl[i].exp_er});
            chk("tbl_deq_valid", {63'd0, obs_dv},  {63'd0, tbl[i].exp_dv});
            chk("tbl_count",     {61'd0, obs_cnt}, {61'd0, tbl[i].exp_cnt});
            chk("tbl_afull",     {63'd0, obs_af},  {63'd0, tbl[i].exp_af});
        end

        // Second fill/drain of 6 entries so both pointers wrap.
        for (int i = 0; i < 6; i++)
            run_cycle(1'b1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), (i >= 2), 1'b0);
        for (int i = 0; i < 5; i++)
            run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("wrap_empty", {61'd0, count}, 64'd0);

        // Concurrent enqueue/dequeue at count=2 for 10 cycles.
        run_cycle(1'b1, 32'h200, 32'hC000_0000, 1'b0, 1'b0);
        run_cycle(1'b1, 32'h204, 32'hC000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b1, 32'h208 + 32'(i * 4), 32'hC000_0002 + 32'(i), 1'b1, 1'b0);
            chk("conc_count", {61'd0, count}, 64'd2);
        end

        // Flush with count=3 and both handshakes active.
        run_cycle(1'b1, 32'h300, 32'hD000_0000, 1'b0, 1'b0);
        chk("pre_flush_count", {61'd0, count}, 64'd3);
        run_cycle(1'b1, 32'h304, 32'hD000_0001, 1'b1, 1'b1);
        chk("flush_deq_valid", {63'd0, obs_dv},  64'd0);
        chk("flush_enq_ready", {63'd0, obs_er},  64'd0);
        chk("flush_count",     {61'd0, obs_cnt}, 64'd0);
        run_cycle(1'b1, 32'h40, 32'hE000_0040, 1'b0, 1'b0);
        run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with count=2.
        run_cycle(1'b1, 32'h400, 32'hF000_0000, 1'b0, 1'b0);
        run_cycle(1'b1, 32'h404, 32'hF000_0001, 1'b0, 1'b0);
        chk("pre_rst_count", {61'd0, count}, 64'd2);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_count",     {61'd0, count},     64'd0);
        chk("arst_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("arst_deq_pc",    {32'd0, deq_pc},    64'd0);
        m_q.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Bypass probe: empty buffer, push with decode ready. The model
        // predicts same-cycle delivery with the option, next-cycle without.
        run_cycle(1'b1, 32'h20, 32'hA5A5_0020, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
        chk("byp_same_cycle", {63'd0, obs_dv},  64'd1);
        chk("byp_count",      {61'd0, obs_cnt}, 64'd0);
`else
        chk("nobyp_same_cycle", {63'd0, obs_dv},  64'd0);
        chk("nobyp_count",      {61'd0, obs_cnt}, 64'd1);
`endif
        run_cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
        chk("byp_next_cycle", {63'd0, obs_dv}, 64'd0);
`else
        chk("nobyp_next_cycle", {63'd0, obs_dv}, 64'd1);
`endif
        chk("final_count", {61'd0, count}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
